histo_clip_stretch: RTL
=======================

// Module: histo_clip_stretch
// PURPOSE
//  Per-frame contrast stretch with percentile clipping. Generalised successor of the min/max stretch stage.
//  Builds a coarse luma histogram during active video and finds clipped low/high cutoffs in vertical blanking.
//  Computes a fixed-point reciprocal gain with a sequential divider and applies the stretch to the next frame.
//  Sits between the Y extraction stage and the display formatter; sync signals are delayed to stay aligned.
// PARAMETERS
//  DATA_W   8    luma width
//  BIN_W    5    log2(bin count); bin = pixel[DATA_W-1 -: BIN_W]; SH = DATA_W-BIN_W; BIN_W<=DATA_W
//  CNT_W    20   bin and frame pixel counter width; all counters saturate at 2^CNT_W-1
//  CLIP_CNT 0    pixels discarded from each histogram tail
//  FRAC_W   12   reciprocal fraction bits
// PORTS
//  clk          in   1       pixel clock
//  rst_n        in   1       asynchronous active-low reset
//  i_HSYNC      in   1       hsync
//  i_VSYNC      in   1       vsync; a falling edge ends the frame
//  i_BLANK      in   1       1 = active pixel on i_Y0
//  i_Y0         in   DATA_W  input luma
//  i_bypass     in   1       1 = Y0 follows i_Y0 (histogram still collected)
//  H_SYNC       out  1       i_HSYNC delayed 3
//  V_SYNC       out  1       i_VSYNC delayed 3
//  BLANK        out  1       i_BLANK delayed 3
//  Y0           out  DATA_W  stretched luma
//  display_data out  16      RGB565 grey {Y0[DATA_W-1-:5],Y0[DATA_W-1-:6],Y0[DATA_W-1-:5]}; DATA_W>=6
//  stats_valid  out  1       1-cycle pulse when new lo/hi/gain are committed
// BEHAVIOUR
//  Reset: outputs=0, lo=0, hi=2^DATA_W-1, gain=(2^DATA_W-1)*2^FRAC_W/(2^DATA_W-1)+1 (identity), bins/count=0, FSM=IDLE.
//  VSYNC fall: edge = {vs_d2,vs_d1}==2'b10 on a two-flop history; detected 2 cycles after the pin falls.
//  FSM IDLE: each i_BLANK cycle increments bin[i_Y0>>SH] and the frame count N (saturating). On edge -> SCAN.
//  FSM SCAN: 2^BIN_W cycles, bin k=0..; cum+=bin[k]; bin[k] and N cleared after read.
//   - lo_bin = first k with cum>CLIP_CNT; hi_bin = first k with cum>=N-CLIP_CNT.
//   - Pixels in SCAN/DIV/LOAD are not histogrammed; the stretch path still runs.
//  FSM DIV: restoring divide, DATA_W+FRAC_W cycles; gain = floor((2^DATA_W-1)<<FRAC_W / (hi-lo))+1.
//   - lo = lo_bin<<SH; hi = (hi_bin<<SH)|(2^SH-1).
//  FSM LOAD: 1 cycle; lo/hi/gain committed together; stats_valid=1 -> IDLE.
//  Degenerate cases keep identity stats and skip DIV (still pass LOAD): N<=2*CLIP_CNT, or hi==lo.
//  Blanking requirement: >= 2^BIN_W+DATA_W+FRAC_W+4 cycles. VSYNC edges outside IDLE are ignored; the computation completes.
//  Pixel path, 3 cycles, committed stats sampled in stage 1:
//   - s1: d = (y<=lo)?0:(y-lo)
//   - s2: p = d*gain, width 2*DATA_W+FRAC_W
//   - s3: Y0 = min(p>>FRAC_W, 2^DATA_W-1), or y_d3 if i_bypass (i_bypass sampled in s1)
//  Y0 updates every cycle, including blanking. A LOAD mid-frame cannot occur under the blanking requirement.
//  Reset mid-operation: immediate return to reset state; no stats_valid pulse.
// TESTING
//  1 Reset, 8-bit ramp frame, no prior stats -> Y0==i_Y0 delayed 3 cycles, H/V/BLANK delayed 3.
//  2 CLIP_CNT=0, frame uniform 64..127 -> lo=64, hi=127, gain=16580, 1 stats_valid; next frame 64->0, 96->129, 127->255, 20->0, 200->255.
//  3 CLIP_CNT=64: 64 px@0, 64 px@255, rest 100..163 -> lo=96, hi=167.
//  4 BIN_W=8, frame all 50 -> hi==lo, identity kept; 50->50, stats_valid pulses.
//  5 Extra VSYNC fall during SCAN -> ignored, single stats_valid. rst_n low mid-DIV -> identity stats, IDLE, no pulse.
//  6 CNT_W=4, 40 px of value 10 -> bin saturates at 15, no wrap; N saturates at 15. i_bypass=1 -> Y0=i_Y0 delayed 3.

Source files
------------

// File: rtl/histo_clip_stretch.sv
// Per-frame contrast stretch: coarse luma histogram in active video, percentile-clipped
// cutoffs and reciprocal gain found in vertical blanking, stretch applied to the next frame.
module histo_clip_stretch #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned BIN_W    = 5,
    parameter int unsigned CNT_W    = 20,
    parameter int unsigned CLIP_CNT = 0,
    parameter int unsigned FRAC_W   = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_HSYNC,
    input  logic              i_VSYNC,
    input  logic              i_BLANK,
    input  logic [DATA_W-1:0] i_Y0,
    input  logic              i_bypass,
    output logic              H_SYNC,
    output logic              V_SYNC,
    output logic              BLANK,
    output logic [DATA_W-1:0] Y0,
    output logic [15:0]       display_data,
    output logic              stats_valid
);

    localparam int unsigned NBINS = 1 << BIN_W;
    localparam int unsigned SH    = DATA_W - BIN_W;
    localparam int unsigned QW    = DATA_W + FRAC_W;
    localparam int unsigned PW    = 2 * DATA_W + FRAC_W;
    localparam int unsigned CUM_W = CNT_W + BIN_W + 1;
    localparam int unsigned CW    = $clog2(NBINS + QW + 1);

    localparam logic [DATA_W-1:0]  YMAX     = '1;
    localparam logic [DATA_W-1:0]  LSB_MASK = DATA_W'((1 << SH) - 1);
    localparam logic [QW-1:0]      GAIN_ID  = QW'((1 << FRAC_W) + 1);
    localparam logic [QW-1:0]      DIVIDEND = QW'(YMAX) << FRAC_W;
    localparam logic [CUM_W-1:0]   CLIP_C   = CUM_W'(CLIP_CNT);
    localparam logic [CNT_W+1:0]   CLIP2    = (CNT_W + 2)'(2 * CLIP_CNT);

    typedef enum logic [1:0] {StIdle, StScan, StDiv, StLoad} state_e;

    state_e             state_q, state_d;
    logic               vs_d1, vs_d2, vs_fall;
    logic [CNT_W-1:0]   bins_q [NBINS];
    logic [CNT_W-1:0]   n_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CUM_W-1:0]   cum_q, cum_d, cum_add, hi_thr;
    logic               lo_found_q, lo_found_d, hi_found_q, hi_found_d;
    logic [BIN_W-1:0]   lo_bin_q, lo_bin_d, hi_bin_q, hi_bin_d;
    logic [DATA_W-1:0]  lo_new_q, lo_new_d, div_q, div_d;
    logic [DATA_W-1:0]  rem_q, rem_d;
    logic [QW-1:0]      quo_q, quo_d;
    logic [DATA_W-1:0]  lo_q, lo_d;
    logic [QW-1:0]      gain_q, gain_d;
    logic [BIN_W-1:0]   pix_bin, scan_idx;
    logic               scan_last, div_last, degenerate, ge;
    logic [DATA_W-1:0]  lo_v, hi_v;
    logic [DATA_W:0]    trial, sub;

    assign vs_fall   = vs_d2 & ~vs_d1;
    assign pix_bin   = i_Y0[DATA_W-1 -: BIN_W];
    assign scan_idx  = cnt_q[BIN_W-1:0];
    assign scan_last = (cnt_q == CW'(NBINS - 1));
    assign div_last  = (cnt_q == CW'(QW - 1));
    assign cum_add   = cum_q + CUM_W'(bins_q[scan_idx]);
    assign hi_thr    = CUM_W'(n_q) - CLIP_C;
    assign trial     = {rem_q, quo_q[QW-1]};
    assign ge        = (trial >= {1'b0, div_q});
    assign sub       = trial - {1'b0, div_q};

    // Histogram: counted only in IDLE, cleared bin-by-bin as the scan reads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBINS; i++) bins_q[i] <= '0;
            n_q <= '0;
        end else if (state_q == StIdle) begin
            if (i_BLANK) begin
                if (bins_q[pix_bin] != '1) bins_q[pix_bin] <= bins_q[pix_bin] + 1'b1;
                if (n_q != '1) n_q <= n_q + 1'b1;
            end
        end else if (state_q == StScan) begin
            bins_q[scan_idx] <= '0;
            if (scan_last) n_q <= '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cum_d      = cum_q;
        lo_found_d = lo_found_q;
        hi_found_d = hi_found_q;
        lo_bin_d   = lo_bin_q;
        hi_bin_d   = hi_bin_q;
        lo_new_d   = lo_new_q;
        div_d      = div_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        lo_d       = lo_q;
        gain_d     = gain_q;
        lo_v       = '0;
        hi_v       = '0;
        degenerate = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (vs_fall) begin
                    state_d    = StScan;
                    cnt_d      = '0;
                    cum_d      = '0;
                    lo_found_d = 1'b0;
                    hi_found_d = 1'b0;
                    lo_bin_d   = '0;
                    hi_bin_d   = '1;
                end
            end
            StScan: begin
                cum_d = cum_add;
                cnt_d = cnt_q + 1'b1;
                if (!lo_found_q && (cum_add > CLIP_C)) begin
                    lo_found_d = 1'b1;
                    lo_bin_d   = scan_idx;
                end
                if (!hi_found_q && (cum_add >= hi_thr)) begin
                    hi_found_d = 1'b1;
                    hi_bin_d   = scan_idx;
                end
                lo_v       = DATA_W'(lo_bin_d) << SH;
                hi_v       = (DATA_W'(hi_bin_d) << SH) | LSB_MASK;
                degenerate = ({2'b00, n_q} <= CLIP2) || (hi_v == lo_v);
                if (scan_last) begin
                    cnt_d = '0;
                    if (degenerate) begin
                        // quotient preset so that LOAD's +1 yields the identity gain
                        lo_new_d = '0;
                        quo_d    = GAIN_ID - 1'b1;
                        state_d  = StLoad;
                    end else begin
                        lo_new_d = lo_v;
                        div_d    = hi_v - lo_v;
                        rem_d    = '0;
                        quo_d    = DIVIDEND;
                        state_d  = StDiv;
                    end
                end
            end
            StDiv: begin
                rem_d = ge ? sub[DATA_W-1:0] : trial[DATA_W-1:0];
                quo_d = {quo_q[QW-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                if (div_last) state_d = StLoad;
            end
            StLoad: begin
                lo_d    = lo_new_q;
                gain_d  = quo_q + 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            vs_d1      <= 1'b0;
            vs_d2      <= 1'b0;
            cnt_q      <= '0;
            cum_q      <= '0;
            lo_found_q <= 1'b0;
            hi_found_q <= 1'b0;
            lo_bin_q   <= '0;
            hi_bin_q   <= '0;
            lo_new_q   <= '0;
            div_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            lo_q       <= '0;
            gain_q     <= GAIN_ID;
        end else begin
            state_q    <= state_d;
            vs_d1      <= i_VSYNC;
            vs_d2      <= vs_d1;
            cnt_q      <= cnt_d;
            cum_q      <= cum_d;
            lo_found_q <= lo_found_d;
            hi_found_q <= hi_found_d;
            lo_bin_q   <= lo_bin_d;
            hi_bin_q   <= hi_bin_d;
            lo_new_q   <= lo_new_d;
            div_q      <= div_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            lo_q       <= lo_d;
            gain_q     <= gain_d;
        end
    end

    assign stats_valid = (state_q == StLoad);

    // Three-stage pixel path; syncs travel alongside.
    logic [DATA_W-1:0]   y1_q, y2_q, d1_q;
    logic [QW-1:0]       gain1_q;
    logic [2*DATA_W-1:0] p2_q;
    logic                byp1_q, byp2_q;
    logic [2:0]          hs_sr, vs_sr, bl_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y1_q    <= '0;
            d1_q    <= '0;
            gain1_q <= '0;
            byp1_q  <= 1'b0;
            y2_q    <= '0;
            p2_q    <= '0;
            byp2_q  <= 1'b0;
            Y0      <= '0;
            hs_sr   <= '0;
            vs_sr   <= '0;
            bl_sr   <= '0;
        end else begin
            y1_q    <= i_Y0;
            d1_q    <= (i_Y0 <= lo_q) ? '0 : (i_Y0 - lo_q);
            gain1_q <= gain_q;
            byp1_q  <= i_bypass;
            y2_q    <= y1_q;
            p2_q    <= (2 * DATA_W)'((PW'(d1_q) * PW'(gain1_q)) >> FRAC_W);
            byp2_q  <= byp1_q;
            if (byp2_q) Y0 <= y2_q;
            else        Y0 <= (|p2_q[2*DATA_W-1:DATA_W]) ? YMAX : p2_q[DATA_W-1:0];
            hs_sr   <= {hs_sr[1:0], i_HSYNC};
            vs_sr   <= {vs_sr[1:0], i_VSYNC};
            bl_sr   <= {bl_sr[1:0], i_BLANK};
        end
    end

    assign H_SYNC       = hs_sr[2];
    assign V_SYNC       = vs_sr[2];
    assign BLANK        = bl_sr[2];
    assign display_data = {Y0[DATA_W-1 -: 5], Y0[DATA_W-1 -: 6], Y0[DATA_W-1 -: 5]};

endmodule
